// File: rtl/router_pkt_tx.sv
// router_pkt_tx: source end of the router byte protocol.
// Sends {len,dest} header, payload bytes from a host-loaded buffer, then an
// XOR parity byte, holding the current byte while the router asserts busy.
module router_pkt_tx #(
  parameter int DEPTH = 64,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [1:0]    dest_addr,
  input  logic [5:0]    pld_len,
  input  logic          corrupt_parity,
  input  logic          busy,
  output logic          pkt_valid,
  output logic [DW-1:0] data_out,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          start_err
);

  typedef enum logic [1:0] {IDLE, HDR, PLD, PAR} state_t;

  state_t        state;
  logic [DW-1:0] pld_buf [DEPTH];
  logic [5:0]    len_q;
  logic [5:0]    cnt;
  logic          corrupt_q;
  logic [DW-1:0] parity;

  // Payload buffer: host writes only land while no packet is in flight.
  always_ff @(posedge clock) begin
    if (wr_en && !tx_busy)
      pld_buf[wr_addr] <= wr_data;
  end

  // Transmit FSM; every output is registered here.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      start_err <= 1'b0;
      parity    <= '0;
      cnt       <= '0;
      len_q     <= '0;
      corrupt_q <= 1'b0;
    end else begin
      tx_done   <= 1'b0;
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pld_len == 6'd0 || dest_addr == 2'b11) begin
              start_err <= 1'b1;
            end else begin
              len_q     <= pld_len;
              corrupt_q <= corrupt_parity;
              state     <= HDR;
              data_out  <= {pld_len, dest_addr};
              parity    <= {pld_len, dest_addr};
              pkt_valid <= 1'b1;
              tx_busy   <= 1'b1;
              cnt       <= '0;
            end
          end
        end
        HDR: begin
          if (!busy) begin
            state    <= PLD;
            data_out <= pld_buf[0];
            cnt      <= 6'd1;
          end
        end
        PLD: begin
          // cnt counts payload bytes already placed on the bus.
          if (!busy) begin
            parity <= parity ^ data_out;
            if (cnt < len_q) begin
              data_out <= pld_buf[cnt];
              cnt      <= cnt + 6'd1;
            end else begin
              state     <= PAR;
              pkt_valid <= 1'b0;
              data_out  <= parity ^ data_out ^ {{(DW-1){1'b0}}, corrupt_q};
            end
          end
        end
        PAR: begin
          if (!busy) begin
            state    <= IDLE;
            tx_done  <= 1'b1;
            tx_busy  <= 1'b0;
            data_out <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
